// File: rtl/cc_branch_eval.sv
// cc_branch_eval
//   Execute-stage read side of the condition-code register. It evaluates the
//   jXX/cmovXX condition from the registered {ZF,SF,OF} flags and drives the
//   zero-latency e_cnd, which is used to suppress the cmov destination. The
//   outcome is registered into the E->M pipeline register together with a
//   mispredict flag. jXX is predicted taken, so a not-taken jXX is a
//   mispredict and m_valA carries the redirect PC. Saturating statistics
//   counters track branches and mispredicts.
//
// Ports
//   clk           rising-edge clock
//   async_reset   asynchronous active-low reset, clears all state
//   reset         synchronous active-high reset, same values as async_reset
//   stall         hold the M register and the counters
//   bubble        load a nop into M (wins over stall)
//   e_valid       E-stage instruction valid
//   e_icode       E-stage icode (2 = cmovXX/rrmovq, 7 = jXX)
//   e_ifun        condition function
//   cc            {ZF,SF,OF}
//   e_valA        fall-through PC for jXX, data otherwise
//   e_cnd         combinational condition result
//   m_valid       registered valid
//   m_icode       registered icode
//   m_cnd         registered condition result
//   m_mispredict  registered not-taken flag for a jXX
//   m_bad_ifun    registered flag for ifun > 6 on a jXX/cmovXX
//   m_valA        registered valA
//   branch_cnt    valid jXX loaded into M, saturating
//   mispred_cnt   mispredicted jXX loaded into M, saturating
module cc_branch_eval #(
  parameter int CNT_W = 16,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             reset,
  input  logic             stall,
  input  logic             bubble,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [2:0]       cc,
  input  logic [W-1:0]     e_valA,
  output logic             e_cnd,
  output logic             m_valid,
  output logic [3:0]       m_icode,
  output logic             m_cnd,
  output logic             m_mispredict,
  output logic             m_bad_ifun,
  output logic [W-1:0]     m_valA,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] ICODE_NOP  = 4'd1;
  localparam logic [3:0] ICODE_CMOV = 4'd2;
  localparam logic [3:0] ICODE_JXX  = 4'd7;

  logic zf, sf, of, lt;
  logic tbl_cnd;
  logic is_jxx, is_cond_op;
  logic mispredict_next, bad_ifun_next;
  logic branch_full, mispred_full;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];
  assign lt = sf ^ of;

  always_comb begin
    tbl_cnd = 1'b0;
    case (e_ifun)
      4'd0:    tbl_cnd = 1'b1;
      4'd1:    tbl_cnd = lt | zf;
      4'd2:    tbl_cnd = lt;
      4'd3:    tbl_cnd = zf;
      4'd4:    tbl_cnd = ~zf;
      4'd5:    tbl_cnd = ~lt;
      4'd6:    tbl_cnd = ~lt & ~zf;
      default: tbl_cnd = 1'b0;
    endcase
  end

  assign is_jxx     = e_valid & (e_icode == ICODE_JXX);
  assign is_cond_op = e_valid & ((e_icode == ICODE_JXX) | (e_icode == ICODE_CMOV));

  assign e_cnd           = is_cond_op & tbl_cnd;
  assign mispredict_next = is_jxx & ~tbl_cnd;
  assign bad_ifun_next   = is_cond_op & (e_ifun > 4'd6);

  assign branch_full  = &branch_cnt;
  assign mispred_full = &mispred_cnt;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      m_valid      <= 1'b0;
      m_icode      <= ICODE_NOP;
      m_cnd        <= 1'b0;
      m_mispredict <= 1'b0;
      m_bad_ifun   <= 1'b0;
      m_valA       <= '0;
      branch_cnt   <= '0;
      mispred_cnt  <= '0;
    end else if (reset) begin
      m_valid      <= 1'b0;
      m_icode      <= ICODE_NOP;
      m_cnd        <= 1'b0;
      m_mispredict <= 1'b0;
      m_bad_ifun   <= 1'b0;
      m_valA       <= '0;
      branch_cnt   <= '0;
      mispred_cnt  <= '0;
    end else if (bubble) begin
      m_valid      <= 1'b0;
      m_icode      <= ICODE_NOP;
      m_cnd        <= 1'b0;
      m_mispredict <= 1'b0;
      m_bad_ifun   <= 1'b0;
      m_valA       <= '0;
    end else if (!stall) begin
      m_valid      <= e_valid;
      m_icode      <= e_icode;
      m_cnd        <= e_cnd;
      m_mispredict <= mispredict_next;
      m_bad_ifun   <= bad_ifun_next;
      m_valA       <= e_valA;
      if (is_jxx && !branch_full)
        branch_cnt <= branch_cnt + 1'b1;
      if (mispredict_next && !mispred_full)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cc_branch_eval.sv
// tb_cc_branch_eval
//   Directed vector table, hand-written multi-cycle sequences and randomized
//   stimulus, all compared against a behavioural model of the condition
//   rules and the M-register/counter behaviour. A second instance with
//   4-bit counters shares the stimulus so that saturation is reachable.
module tb_cc_branch_eval;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          async_reset, reset, stall, bubble, e_valid;
  logic [3:0]    e_icode, e_ifun;
  logic [2:0]    cc;
  logic [W-1:0]  e_valA;

  logic          e_cnd, m_valid, m_cnd, m_mispredict, m_bad_ifun;
  logic [3:0]    m_icode;
  logic [W-1:0]  m_valA;
  logic [15:0]   branch_cnt, mispred_cnt;

  logic          n_e_cnd, n_m_valid, n_m_cnd, n_m_mispredict, n_m_bad_ifun;
  logic [3:0]    n_m_icode;
  logic [W-1:0]  n_m_valA;
  logic [3:0]    n_branch_cnt, n_mispred_cnt;

  always #5 clk = ~clk;

  cc_branch_eval #(.CNT_W(16), .W(W)) dut (
    .clk(clk), .async_reset(async_reset), .reset(reset), .stall(stall),
    .bubble(bubble), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .cc(cc), .e_valA(e_valA), .e_cnd(e_cnd), .m_valid(m_valid),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_mispredict(m_mispredict),
    .m_bad_ifun(m_bad_ifun), .m_valA(m_valA), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  cc_branch_eval #(.CNT_W(4), .W(W)) dut_n (
    .clk(clk), .async_reset(async_reset), .reset(reset), .stall(stall),
    .bubble(bubble), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .cc(cc), .e_valA(e_valA), .e_cnd(n_e_cnd), .m_valid(n_m_valid),
    .m_icode(n_m_icode), .m_cnd(n_m_cnd), .m_mispredict(n_m_mispredict),
    .m_bad_ifun(n_m_bad_ifun), .m_valA(n_m_valA), .branch_cnt(n_branch_cnt),
    .mispred_cnt(n_mispred_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          x_valid, x_cnd, x_mis, x_bad;
  logic [3:0]  x_icode;
  logic [W-1:0] x_valA;
  int          x_br, x_mp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_cnd(input bit v, input logic [3:0] ic,
                                 input logic [3:0] fn, input logic [2:0] c);
    bit zf, sf, of, lt;
    zf = c[2]; sf = c[1]; of = c[0];
    lt = (sf != of);
    if (!v || !(ic == 4'd2 || ic == 4'd7)) return 1'b0;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int bits);
    int top;
    top = (1 << bits) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_clear(input bit counters);
    x_valid = 0; x_icode = 4'd1; x_cnd = 0; x_mis = 0; x_bad = 0; x_valA = '0;
    if (counters) begin x_br = 0; x_mp = 0; end
  endtask

  // Applies the rules of one rising edge to the model using the current inputs.
  task automatic model_edge();
    bit c, j;
    if (reset) model_clear(1);
    else if (bubble) model_clear(0);
    else if (!stall) begin
      c = ref_cnd(e_valid, e_icode, e_ifun, cc);
      j = e_valid && (e_icode == 4'd7);
      x_valid = e_valid;
      x_icode = e_icode;
      x_cnd   = c;
      x_mis   = j && !c;
      x_bad   = e_valid && (e_icode == 4'd2 || e_icode == 4'd7) && (e_ifun > 4'd6);
      x_valA  = e_valA;
      if (j) x_br++;
      if (j && !c) x_mp++;
    end
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".m_valid"},      m_valid,      x_valid);
    chk({tag, ".m_icode"},      m_icode,      x_icode);
    chk({tag, ".m_cnd"},        m_cnd,        x_cnd);
    chk({tag, ".m_mispredict"}, m_mispredict, x_mis);
    chk({tag, ".m_bad_ifun"},   m_bad_ifun,   x_bad);
    chk({tag, ".m_valA"},       m_valA,       x_valA);
    chk({tag, ".branch_cnt"},   branch_cnt,   sat(x_br, 16));
    chk({tag, ".mispred_cnt"},  mispred_cnt,  sat(x_mp, 16));
    chk({tag, ".n_m_valid"},    n_m_valid,    x_valid);
    chk({tag, ".n_branch_cnt"}, n_branch_cnt, sat(x_br, 4));
    chk({tag, ".n_mispred_cnt"},n_mispred_cnt,sat(x_mp, 4));
  endtask

  task automatic drive(input bit v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [2:0] c, input logic [W-1:0] va);
    e_valid = v; e_icode = ic; e_ifun = fn; cc = c; e_valA = va;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_m(tag);
  endtask

  task automatic sync_reset();
    reset = 1; stall = 0; bubble = 0;
    cycle("sreset");
    reset = 0;
  endtask

  typedef struct {
    bit         v;
    logic [3:0] ic;
    logic [3:0] fn;
    logic [2:0] c;
    bit         cnd;
    bit         mis;
    bit         bad;
  } vec_t;

  vec_t vt[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1, 4'd7, 4'd3, 3'b100, 1, 0, 0};
    vt[1]  = '{1, 4'd7, 4'd6, 3'b010, 0, 1, 0};
    vt[2]  = '{1, 4'd2, 4'd0, 3'b000, 1, 0, 0};
    vt[3]  = '{1, 4'd2, 4'd1, 3'b000, 0, 0, 0};
    vt[4]  = '{1, 4'd2, 4'd1, 3'b011, 0, 0, 0};
    vt[5]  = '{1, 4'd2, 4'd2, 3'b001, 1, 0, 0};
    vt[6]  = '{1, 4'd7, 4'd4, 3'b100, 0, 1, 0};
    vt[7]  = '{1, 4'd7, 4'd5, 3'b011, 1, 0, 0};
    vt[8]  = '{1, 4'd7, 4'd9, 3'b111, 0, 1, 1};
    vt[9]  = '{0, 4'd7, 4'd0, 3'b000, 0, 0, 0};
    vt[10] = '{1, 4'd6, 4'd0, 3'b000, 0, 0, 0};
    vt[11] = '{1, 4'd2, 4'd6, 3'b000, 1, 0, 0};
    vt[12] = '{1, 4'd7, 4'd1, 3'b100, 1, 0, 0};

    async_reset = 0; reset = 0; stall = 0; bubble = 0;
    drive(0, 4'd0, 4'd0, 3'b000, '0);
    model_clear(1);
    #12;
    check_m("por");
    @(negedge clk);
    async_reset = 1;

    // je taken
    drive(1, 4'd7, 4'd3, 3'b100, 64'h40);
    #1 chk("je.e_cnd", e_cnd, 1);
    cycle("je");
    chk("je.m_cnd", m_cnd, 1);
    chk("je.branch_cnt", branch_cnt, 1);
    chk("je.mispred_cnt", mispred_cnt, 0);

    // jg not taken with SF only
    sync_reset();
    drive(1, 4'd7, 4'd6, 3'b010, 64'h1C);
    #1 chk("jg.e_cnd", e_cnd, 0);
    cycle("jg");
    chk("jg.m_mispredict", m_mispredict, 1);
    chk("jg.m_valA", m_valA, 64'h1C);
    chk("jg.branch_cnt", branch_cnt, 1);
    chk("jg.mispred_cnt", mispred_cnt, 1);

    // directed table
    sync_reset();
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].ic, vt[i].fn, vt[i].c, 64'h1000 + 64'(i));
      #1 chk($sformatf("vt%0d.e_cnd", i), e_cnd, vt[i].cnd);
      cycle($sformatf("vt%0d", i));
      chk($sformatf("vt%0d.tm_cnd", i), m_cnd, vt[i].cnd);
      chk($sformatf("vt%0d.tm_mis", i), m_mispredict, vt[i].mis);
      chk($sformatf("vt%0d.tm_bad", i), m_bad_ifun, vt[i].bad);
    end

    // cmov sweep: all cc x ifun 0..6, counters stay 0
    sync_reset();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 7; f++) begin
        drive(1, 4'd2, 4'(f), 3'(c), 64'(c * 16 + f));
        #1 chk($sformatf("sweep_c%0d_f%0d", c, f), e_cnd, ref_cnd(1, 4'd2, 4'(f), 3'(c)));
        cycle("sweep");
      end
    chk("sweep.branch_cnt", branch_cnt, 0);

    // stall for 3 cycles while cc toggles
    drive(1, 4'd7, 4'd9, 3'b000, 64'hABC);
    cycle("pre_stall");
    stall = 1;
    drive(1, 4'd7, 4'd3, 3'b100, 64'h55);
    for (int k = 0; k < 3; k++) begin
      cc = 3'(k * 3 + 1);
      cycle($sformatf("stall%0d", k));
    end
    chk("stall.m_bad_ifun", m_bad_ifun, 1);
    chk("stall.m_valA", m_valA, 64'hABC);

    // bubble with stall
    bubble = 1;
    cycle("bubble_stall");
    chk("bubble.m_icode", m_icode, 4'd1);
    chk("bubble.m_valid", m_valid, 0);
    bubble = 0; stall = 0;

    // saturation: 17 not-taken jXX
    sync_reset();
    drive(1, 4'd7, 4'd3, 3'b000, 64'h77);
    for (int k = 0; k < 17; k++) cycle("sat");
    chk("sat.n_branch_cnt", n_branch_cnt, 15);
    chk("sat.n_mispred_cnt", n_mispred_cnt, 15);
    chk("sat.branch_cnt", branch_cnt, 17);

    // async reset mid-cycle
    #3 async_reset = 0;
    model_clear(1);
    #1 check_m("arst_now");
    @(posedge clk); #1 check_m("arst_hold");
    #2 async_reset = 1;
    drive(1, 4'd7, 4'd0, 3'b000, 64'h99);
    cycle("arst_release");
    chk("arst.branch_cnt", branch_cnt, 1);

    // randomized
    for (int k = 0; k < 400; k++) begin
      reset  = ($urandom_range(0, 99) < 2);
      bubble = ($urandom_range(0, 99) < 10);
      stall  = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 3))
        0: e_icode = 4'd2;
        1: e_icode = 4'd7;
        default: e_icode = 4'($urandom_range(0, 15));
      endcase
      e_valid = ($urandom_range(0, 9) < 8);
      e_ifun  = 4'($urandom_range(0, 15));
      cc      = 3'($urandom_range(0, 7));
      e_valA  = {$urandom, $urandom};
      #1 chk("rnd.e_cnd", e_cnd, ref_cnd(e_valid, e_icode, e_ifun, cc));
      chk("rnd.n_e_cnd", n_e_cnd, ref_cnd(e_valid, e_icode, e_ifun, cc));
      cycle("rnd");
      chk("rnd.n_m_valA", n_m_valA, x_valA);
      chk("rnd.n_m_icode", n_m_icode, x_icode);
      chk("rnd.n_m_flags", {n_m_cnd, n_m_mispredict, n_m_bad_ifun}, {x_cnd, x_mis, x_bad});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_branch_eval.md
Name: cc_branch_eval

Overview:
- Read side of the condition-code register.
- Sits in the Execute stage and consumes the registered {ZF,SF,OF} flags to evaluate jXX/cmovXX conditions.
- Drives the combinational e_cnd used for cmov destination suppression.
- Registers the outcome into the E->M pipeline register together with a branch-mispredict flag (jXX is predicted taken), and keeps saturating branch/mispredict statistics counters.

Parameters:
- CNT_W, 16, width of the branch and mispredict statistics counters.
- W, 64, width of the valA fall-through PC passthrough.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- async_reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the M register and counters.
- bubble  in  1  load a nop into the M register.
- e_valid  in  1  E-stage instruction valid.
- e_icode  in  4  E-stage icode (2 = cmovXX/rrmovq, 7 = jXX).
- e_ifun  in  4  condition function.
- cc  in  3  {ZF,SF,OF} from the condition-code register.
- e_valA  in  W  fall-through PC for jXX, data otherwise.
- e_cnd  out  1  combinational condition result.
- m_valid  out  1  registered valid.
- m_icode  out  4  registered icode.
- m_cnd  out  1  registered condition.
- m_mispredict  out  1  registered: jXX not taken.
- m_bad_ifun  out  1  registered: ifun > 6 on a jXX/cmovXX.
- m_valA  out  W  registered valA (redirect PC on mispredict).
- branch_cnt  out  CNT_W  valid jXX instructions retired into M.
- mispred_cnt  out  CNT_W  mispredicted jXX instructions.

Behaviour:
- Condition table, with ZF=cc[2], SF=cc[1], OF=cc[0]:
  - ifun 0 -> 1
  - ifun 1 (le) -> (SF^OF)|ZF
  - ifun 2 (l) -> SF^OF
  - ifun 3 (e) -> ZF
  - ifun 4 (ne) -> ~ZF
  - ifun 5 (ge) -> ~(SF^OF)
  - ifun 6 (g) -> ~(SF^OF)&~ZF
  - ifun 7..15 -> 0, and bad_ifun = 1
- e_cnd:
  - Equals the table result when e_valid and e_icode is 2 or 7; otherwise 0.
  - Purely combinational from cc in the same cycle, with zero latency.
  - cc is used as presented; there is no internal flag copy.
- mispredict_next = e_valid & (e_icode==7) & ~cnd.
- bad_ifun_next = e_valid & (e_icode is 2 or 7) & (e_ifun>6).
- M register priority:
  - async_reset low: all outputs cleared — m_valid=0, m_icode=1 (nop), m_cnd=0, m_mispredict=0, m_bad_ifun=0, m_valA=0, both counters 0. Values hold while async_reset stays low.
  - else reset=1 at the edge: same values as async_reset.
  - else bubble=1: m_valid=0, m_icode=1, m_cnd/m_mispredict/m_bad_ifun=0, m_valA=0. Counters hold. Bubble wins over stall.
  - else stall=1: all registers and counters hold.
  - else: load e_valid, e_icode, the cnd result, mispredict_next, bad_ifun_next and e_valA.
- Latency: e_cnd has 0 cycles; all m_* outputs and counters have 1 cycle.
- Counters:
  - On a normal load with e_valid & e_icode==7: branch_cnt += 1, and mispred_cnt += 1 if cnd=0.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
  - A jXX with a bad ifun counts as both a branch and a mispredict (cnd=0).
- Invalid instructions (e_valid=0) never set cnd, mispredict or bad_ifun, and never count, regardless of icode/ifun.
- Async reset deasserting mid-stream: the first rising edge after deassertion performs a normal load.
- cc changing while stalled has no effect on the M register.

Test Plan:
- cc=3'b100 (ZF), valid jXX ifun 3 (je), valA=64'h40 -> e_cnd=1. Next edge: m_cnd=1, m_mispredict=0, branch_cnt=1, mispred_cnt=0.
- cc=3'b010 (SF only), valid jXX ifun 6 (jg), valA=64'h1C -> e_cnd=0. Next edge: m_mispredict=1, m_valA=64'h1C, branch_cnt=1, mispred_cnt=1.
- Sweep all 8 cc values × ifun 0..6 for icode 2 -> e_cnd matches the table (56 checks). Counters stay 0.
- Valid jXX ifun 9 -> e_cnd=0. Next edge: m_bad_ifun=1, m_mispredict=1, both counters increment.
- Stall high for 3 cycles while jXX is presented and cc toggles -> m_* and counters unchanged.
- Bubble+stall together -> m_valid=0, m_icode=1.
- Preload near saturation: CNT_W=4, drive 17 not-taken jXX -> both counters stop at 15.
- async_reset pulsed low mid-cycle -> all outputs clear immediately with no clock edge; first edge after release loads normally.
